// File: rtl/mixer_i2s_tx_if.sv
// Mono sample handshake between the mixer (master) and the I2S transmitter (slave).
// The mixer answers mixed_ready with a one-cycle mixed_valid pulse one cycle later.
interface mixer_i2s_tx_if #(
    parameter int AUDIO_WIDTH_P = 24
);
    logic [AUDIO_WIDTH_P-1:0] mixed_data;
    logic                     mixed_valid;
    logic                     mixed_ready;

    modport master (
        output mixed_data,
        output mixed_valid,
        input  mixed_ready
    );

    modport slave (
        input  mixed_data,
        input  mixed_valid,
        output mixed_ready
    );
endinterface

// File: rtl/mixer_i2s_tx.sv
// Buffers mono mixer samples in a small FIFO and sends each one as a stereo I2S frame
// (same sample in both slots, MSB first, left-justified, one-bit lrclk delay).
module mixer_i2s_tx #(
    parameter int AUDIO_WIDTH_P = 24,
    parameter int SLOT_WIDTH_P  = 32,
    parameter int FIFO_DEPTH_P  = 8,
    parameter int BCLK_DIV_P    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    mixer_i2s_tx_if.slave                   mix,
    input  logic                            cr_enable,
    output logic                            i2s_bclk,
    output logic                            i2s_lrclk,
    output logic                            i2s_sdata,
    output logic [$clog2(FIFO_DEPTH_P):0]   sr_fifo_level,
    output logic [15:0]                     sr_underflow_cnt,
    output logic [15:0]                     sr_overflow_cnt
);
    localparam int LVL_W = $clog2(FIFO_DEPTH_P) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH_P);
    localparam int B_W   = $clog2(2 * SLOT_WIDTH_P);
    localparam int DIV_W = $clog2(BCLK_DIV_P);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                   r_state, w_state_nxt;
    logic                     w_start, w_stop, w_run;

    logic [DIV_W-1:0]         r_div;
    logic                     r_bclk, r_lrclk, r_sdata;
    logic [B_W-1:0]           r_b;
    logic [AUDIO_WIDTH_P-1:0] r_sample;

    logic [AUDIO_WIDTH_P-1:0] r_mem [FIFO_DEPTH_P];
    logic [PTR_W-1:0]         r_wptr, r_rptr;
    logic [LVL_W-1:0]         r_level;
    logic                     r_ready;
    logic [15:0]              r_udf_cnt, r_ovf_cnt;

    logic                     w_tc, w_fall, w_pop, w_empty, w_full;
    logic                     w_pop_ok, w_push_ok, w_ovf, w_udf;
    logic [B_W-1:0]           w_b_nxt, w_b_eff, w_slot_bit;
    logic [LVL_W-1:0]         w_level_nxt;
    logic [AUDIO_WIDTH_P-1:0] w_sample_nxt, w_shl;
    logic                     w_sdata_nxt, w_lrclk_nxt;

    // Run/idle control: edges of cr_enable start or abort the serial engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            ST_IDLE: if (cr_enable) begin
                w_start     = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: if (!cr_enable) begin
                w_stop      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_run = (r_state == ST_RUN) && cr_enable;

    always_comb begin
        w_tc     = (r_div == DIV_W'(BCLK_DIV_P - 1));
        w_fall   = w_run && w_tc && r_bclk;
        w_b_nxt  = (r_b == B_W'(2 * SLOT_WIDTH_P - 1)) ? '0 : r_b + B_W'(1);
        w_pop    = w_start || (w_fall && (w_b_nxt == '0));
        w_empty  = (r_level == '0);
        w_full   = (r_level == LVL_W'(FIFO_DEPTH_P));
        w_pop_ok = w_pop && !w_empty;
        // A full FIFO still accepts a sample when a frame-start pop frees a slot that cycle
        w_push_ok = mix.mixed_valid && (!w_full || w_pop_ok);
        w_ovf     = mix.mixed_valid && !w_push_ok;
        w_udf     = w_pop && w_empty;
        w_level_nxt = w_stop ? '0
                    : r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop_ok);

        w_sample_nxt = r_sample;
        if (w_pop) w_sample_nxt = w_empty ? '0 : r_mem[r_rptr];

        w_b_eff    = w_start ? '0 : w_b_nxt;
        w_slot_bit = (w_b_eff >= B_W'(SLOT_WIDTH_P)) ? w_b_eff - B_W'(SLOT_WIDTH_P) : w_b_eff;
        // Shifting past the sample width yields the zero padding of the slot tail
        w_shl       = w_sample_nxt << w_slot_bit;
        w_sdata_nxt = w_shl[AUDIO_WIDTH_P-1];
        w_lrclk_nxt = (w_b_eff >= B_W'(SLOT_WIDTH_P - 1)) &&
                      (w_b_eff <= B_W'(2 * SLOT_WIDTH_P - 2));
    end

    // Divider and serial engine; sdata/lrclk only move on bclk falling edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_bclk   <= 1'b0;
            r_lrclk  <= 1'b0;
            r_sdata  <= 1'b0;
            r_b      <= '0;
            r_sample <= '0;
        end else if (w_stop) begin
            r_div    <= '0;
            r_bclk   <= 1'b0;
            r_lrclk  <= 1'b0;
            r_sdata  <= 1'b0;
            r_b      <= '0;
            r_sample <= '0;
        end else if (w_start || w_run) begin
            r_div    <= (w_start || w_tc) ? '0 : r_div + DIV_W'(1);
            r_sample <= w_sample_nxt;
            if (w_start)   r_bclk <= 1'b0;
            else if (w_tc) r_bclk <= ~r_bclk;
            if (w_start || w_fall) begin
                r_b     <= w_b_eff;
                r_sdata <= w_sdata_nxt;
                r_lrclk <= w_lrclk_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !w_stop) r_mem[r_wptr] <= mix.mixed_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ready <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            // One slot held back for the mixer's valid that trails ready by a cycle
            r_ready <= cr_enable && (w_level_nxt < LVL_W'(FIFO_DEPTH_P - 1));
            if (w_stop) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_udf_cnt <= '0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_udf && (r_udf_cnt != 16'hFFFF)) r_udf_cnt <= r_udf_cnt + 16'd1;
            if (w_ovf && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign mix.mixed_ready   = r_ready;
    assign i2s_bclk          = r_bclk;
    assign i2s_lrclk         = r_lrclk;
    assign i2s_sdata         = r_sdata;
    assign sr_fifo_level     = r_level;
    assign sr_underflow_cnt  = r_udf_cnt;
    assign sr_overflow_cnt   = r_ovf_cnt;
endmodule

// File: tb/tb_mixer_i2s_tx.sv
// Directed bench for mixer_i2s_tx at default parameters (frame = 64 bclk = 256 clk).
// Expected waveforms come from the I2S framing rules, indexed by cycles since frame start.
module tb_mixer_i2s_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cr_enable = 1'b0;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata;
    logic [3:0]  sr_fifo_level;
    logic [15:0] sr_underflow_cnt, sr_overflow_cnt;

    mixer_i2s_tx_if #(.AUDIO_WIDTH_P(24)) mif ();

    mixer_i2s_tx dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mix              (mif),
        .cr_enable        (cr_enable),
        .i2s_bclk         (i2s_bclk),
        .i2s_lrclk        (i2s_lrclk),
        .i2s_sdata        (i2s_sdata),
        .sr_fifo_level    (sr_fifo_level),
        .sr_underflow_cnt (sr_underflow_cnt),
        .sr_overflow_cnt  (sr_overflow_cnt)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   f0    = 0;
    int   idx   = 0;
    logic seen  = 1'b0;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ebit(input logic [23:0] s, input int b);
        int j;
        j = b % 32;
        if (j < 24) return s[5'(23 - j)];
        return 1'b0;
    endfunction

    function automatic logic elr(input int b);
        return (b >= 31) && (b <= 62);
    endfunction

    function automatic logic [23:0] sval(input int i);
        return 24'h5A3C00 + 24'(i) * 24'h010101;
    endfunction

    // Called with the frame-start edge just past; leaves the bench at k=255
    task automatic check_frame(input logic [23:0] s, input int push_k, input logic [23:0] pd);
        for (int k = 0; k < 256; k++) begin
            chk("bclk",  32'(i2s_bclk),  32'((k / 2) % 2));
            chk("lrclk", 32'(i2s_lrclk), 32'(elr(k / 4)));
            chk("sdata", 32'(i2s_sdata), 32'(ebit(s, k / 4)));
            if (k == push_k) begin
                mif.mixed_valid = 1'b1;
                mif.mixed_data  = pd;
            end
            if (k < 255) begin
                tick();
                mif.mixed_valid = 1'b0;
            end
        end
    endtask

    initial begin
        mif.mixed_valid = 1'b0;
        mif.mixed_data  = '0;

        // Reset held while inputs toggle randomly
        for (int i = 0; i < 10; i++) begin
            mif.mixed_valid = 1'($urandom);
            mif.mixed_data  = 24'($urandom);
            cr_enable       = 1'($urandom);
            tick();
            chk("rst_pins", {28'd0, i2s_bclk, i2s_lrclk, i2s_sdata, mif.mixed_ready}, 32'd0);
            chk("rst_lvl",  32'(sr_fifo_level), 32'd0);
        end
        mif.mixed_valid = 1'b0;
        cr_enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(mif.mixed_ready), 32'd0);
        chk("post_rst_udf",   32'(sr_underflow_cnt), 32'd0);
        chk("post_rst_ovf",   32'(sr_overflow_cnt), 32'd0);

        // One sample, then a single enabled frame
        mif.mixed_valid = 1'b1;
        mif.mixed_data  = 24'hA5A5A5;
        tick();
        mif.mixed_valid = 1'b0;
        chk("push_lvl", 32'(sr_fifo_level), 32'd1);
        chk("ready_dis", 32'(mif.mixed_ready), 32'd0);
        cr_enable = 1'b1;
        tick();
        chk("ready_en", 32'(mif.mixed_ready), 32'd1);
        chk("pop_lvl",  32'(sr_fifo_level), 32'd0);
        check_frame(24'hA5A5A5, -1, '0);
        chk("a5_udf", 32'(sr_underflow_cnt), 32'd0);
        cr_enable = 1'b0;
        tick();
        chk("dis_pins", {29'd0, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);

        // Three empty frames, sample pushed during the third
        cr_enable = 1'b1;
        tick();
        check_frame(24'h0, -1, '0);
        tick();
        check_frame(24'h0, -1, '0);
        tick();
        check_frame(24'h0, 100, 24'h800001);
        chk("udf3", 32'(sr_underflow_cnt), 32'd3);
        chk("lvl1", 32'(sr_fifo_level), 32'd1);
        tick();
        check_frame(24'h800001, -1, '0);
        chk("udf3_hold", 32'(sr_underflow_cnt), 32'd3);
        cr_enable = 1'b0;
        tick();

        // Mixer model: valid follows ready with one registered cycle of delay
        cr_enable = 1'b1;
        tick();
        f0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            mif.mixed_valid = seen;
            if (seen) begin
                idx++;
                mif.mixed_data = sval(idx);
            end
            if (sr_fifo_level == 4'd7) chk("ready_at7", 32'(mif.mixed_ready), 32'd0);
            seen = mif.mixed_ready;
            tick();
        end
        mif.mixed_valid = 1'b0;
        chk("fill_lvl",   32'(sr_fifo_level), 32'd8);
        chk("fill_ovf",   32'(sr_overflow_cnt), 32'd0);
        chk("fill_ready", 32'(mif.mixed_ready), 32'd0);
        chk("fill_udf",   32'(sr_underflow_cnt), 32'd4);
        mif.mixed_valid = 1'b1;
        mif.mixed_data  = 24'hDEAD01;
        tick();
        mif.mixed_valid = 1'b0;
        chk("extra_ovf", 32'(sr_overflow_cnt), 32'd1);
        chk("extra_lvl", 32'(sr_fifo_level), 32'd8);

        // Push coinciding with the frame-start pop on a full FIFO
        while (((cyc - f0) % 256) != 255) tick();
        mif.mixed_valid = 1'b1;
        mif.mixed_data  = sval(9);
        tick();
        mif.mixed_valid = 1'b0;
        chk("pp_lvl", 32'(sr_fifo_level), 32'd8);
        chk("pp_ovf", 32'(sr_overflow_cnt), 32'd1);
        check_frame(sval(1), -1, '0);
        for (int i = 2; i <= 9; i++) begin
            tick();
            check_frame(sval(i), -1, '0);
        end
        chk("drain_lvl", 32'(sr_fifo_level), 32'd0);
        chk("drain_udf", 32'(sr_underflow_cnt), 32'd4);

        // Disable mid-frame at b=40
        tick();
        for (int k = 0; k < 160; k++) begin
            if (k == 50) begin
                mif.mixed_valid = 1'b1;
                mif.mixed_data  = 24'h123456;
            end
            tick();
            mif.mixed_valid = 1'b0;
        end
        chk("b40_lrclk", 32'(i2s_lrclk), 32'd1);
        chk("b40_lvl",   32'(sr_fifo_level), 32'd1);
        chk("b40_ready", 32'(mif.mixed_ready), 32'd1);
        cr_enable = 1'b0;
        tick();
        chk("abort_pins",  {29'd0, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);
        chk("abort_lvl",   32'(sr_fifo_level), 32'd0);
        chk("abort_ready", 32'(mif.mixed_ready), 32'd0);
        chk("abort_udf",   32'(sr_underflow_cnt), 32'd5);
        chk("abort_ovf",   32'(sr_overflow_cnt), 32'd1);

        mif.mixed_valid = 1'b1;
        mif.mixed_data  = 24'h3C3C3C;
        tick();
        mif.mixed_valid = 1'b0;
        cr_enable = 1'b1;
        tick();
        check_frame(24'h3C3C3C, -1, '0);
        chk("reen_udf", 32'(sr_underflow_cnt), 32'd5);

        // Asynchronous reset at b=40 of the following frame
        tick();
        for (int k = 0; k < 160; k++) begin
            if (k == 10) begin
                mif.mixed_valid = 1'b1;
                mif.mixed_data  = 24'h654321;
            end
            tick();
            mif.mixed_valid = 1'b0;
        end
        chk("pre_rst_lr",  32'(i2s_lrclk), 32'd1);
        chk("pre_rst_udf", 32'(sr_underflow_cnt), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("arst_pins", {28'd0, i2s_bclk, i2s_lrclk, i2s_sdata, mif.mixed_ready}, 32'd0);
        chk("arst_lvl",  32'(sr_fifo_level), 32'd0);
        chk("arst_udf",  32'(sr_underflow_cnt), 32'd0);
        chk("arst_ovf",  32'(sr_overflow_cnt), 32'd0);
        cr_enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("final_ready", 32'(mif.mixed_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
